// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the RV M extension.
// One radix-2 step per cycle: shift-add for the MUL family, restoring
// division for DIV/REM. Operands are reduced to magnitudes at accept, and the
// result sign is applied in a single FIX cycle. Divide-by-zero and signed
// overflow bypass the iteration and go straight to DONE.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. req_ready is low while flush is high and outside
// IDLE/DONE. resp_valid is high exactly in DONE. resp_data/resp_tag hold
// while resp_valid & ~resp_ready. The request payload is sampled only at the
// transfer edge.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // acc: product register for multiply; low half holds dividend/quotient for divide
  logic [2*XLEN-1:0] acc_q, acc_d;
  // rem: partial remainder for divide; the shifted trial value is XLEN+1 bits
  logic [XLEN-1:0]   rem_q, rem_d;
  // opa: multiplicand magnitude (multiply) or divisor magnitude (divide)
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              sel_hi_q, sel_hi_d;
  logic              sel_rem_q, sel_rem_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  // Accept-time decode
  logic              accept;
  logic              div_op;
  logic              sgn1_en, sgn2_en;
  logic              sign1, sign2;
  logic              neg_res;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN-1:0]   special_res;

  // Iteration and fix-up datapath
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem_next;
  logic [XLEN-1:0]   div_quo_next;
  logic [2*XLEN-1:0] fix_mul;
  logic [XLEN-1:0]   fix_div_sel;
  logic [XLEN-1:0]   fix_div;
  logic [XLEN-1:0]   fix_res;

  // Request decode: signedness, magnitudes, result sign and special cases
  always_comb begin
    div_op  = req_op[2];
    sgn1_en = div_op ? ~req_op[0] : ((req_op[1:0] == 2'b01) || (req_op[1:0] == 2'b10));
    sgn2_en = div_op ? ~req_op[0] : (req_op[1:0] == 2'b01);
    sign1   = sgn1_en & req_src1[XLEN-1];
    sign2   = sgn2_en & req_src2[XLEN-1];
    mag1    = sign1 ? -req_src1 : req_src1;
    mag2    = sign2 ? -req_src2 : req_src2;
    // Remainder takes the dividend's sign; everything else the product of signs
    neg_res = (div_op & req_op[1]) ? sign1 : (sign1 ^ sign2);
    div_zero = div_op & (req_src2 == '0);
    div_ovf  = div_op & ~req_op[0] & (req_src1 == MIN_NEG) & (req_src2 == '1);
    special  = div_zero | div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = req_op[1] ? req_src1 : '1;
    end else if (div_ovf) begin
      special_res = req_op[1] ? '0 : req_src1;
    end
  end

  // One multiply or divide step, plus sign fix-up and result selection
  always_comb begin
    mul_addend   = acc_q[0] ? opa_q : '0;
    mul_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    mul_next     = {mul_sum, acc_q[XLEN-1:1]};
    div_shift    = {rem_q, acc_q[XLEN-1]};
    div_diff     = {1'b0, div_shift} - {2'b00, opa_q};
    div_ok       = ~div_diff[XLEN+1];
    div_rem_next = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo_next = {acc_q[XLEN-2:0], div_ok};
    fix_mul      = neg_q ? -acc_q : acc_q;
    fix_div_sel  = sel_rem_q ? rem_q : acc_q[XLEN-1:0];
    fix_div      = neg_q ? -fix_div_sel : fix_div_sel;
    if (is_div_q) begin
      fix_res = fix_div;
    end else if (sel_hi_q) begin
      fix_res = fix_mul[2*XLEN-1:XLEN];
    end else begin
      fix_res = fix_mul[XLEN-1:0];
    end
  end

  // Datapath next values: iterate in CALC, register result in FIX, load on accept
  always_comb begin
    acc_d       = acc_q;
    rem_d       = rem_q;
    opa_d       = opa_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    sel_hi_d    = sel_hi_q;
    sel_rem_d   = sel_rem_q;
    neg_d       = neg_q;
    resp_data_d = resp_data_q;
    tag_d       = tag_q;
    case (state_q)
      S_CALC: begin
        if (is_div_q) begin
          acc_d = {acc_q[2*XLEN-1:XLEN], div_quo_next};
          rem_d = div_rem_next;
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        resp_data_d = fix_res;
      end
      default: ;
    endcase
    if (accept) begin
      is_div_d  = div_op;
      sel_hi_d  = (req_op[1:0] != 2'b00);
      sel_rem_d = req_op[1];
      neg_d     = neg_res;
      tag_d     = req_tag;
      rem_d     = '0;
      cnt_d     = CNT_W'(XLEN-1);
      acc_d     = {{XLEN{1'b0}}, (div_op ? mag1 : mag2)};
      opa_d     = div_op ? mag2 : mag1;
      if (special) begin
        resp_data_d = special_res;
      end
    end
  end

  // FSM state register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      opa_q       <= '0;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      sel_hi_q    <= 1'b0;
      sel_rem_q   <= 1'b0;
      neg_q       <= 1'b0;
      resp_data_q <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      opa_q       <= opa_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      sel_hi_q    <= sel_hi_d;
      sel_rem_q   <= sel_rem_d;
      neg_q       <= neg_d;
      resp_data_q <= resp_data_d;
      tag_q       <= tag_d;
    end
  end

  // FSM next state; flush wins over everything and returns to IDLE
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = special ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          state_d = S_DONE;
        end
        S_DONE: begin
          if (accept) begin
            state_d = special ? S_DONE : S_CALC;
          end else if (resp_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: handshake, status and debug view of the state
  always_comb begin
    req_ready  = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & resp_ready));
    accept     = req_valid & req_ready;
    resp_valid = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    resp_data  = resp_data_q;
    resp_tag   = tag_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv (XLEN=32) against
// a plain-arithmetic reference model with an expected-result queue.
module tb_ex_muldiv;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int LAT   = XLEN + 2;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_src1;
  logic [XLEN-1:0]  req_src2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic [1:0]       dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [XLEN-1:0]  exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  int               due_q[$];

  ex_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_res(input logic [2:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op,
                                    input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic ev;
    if (rst) begin
      exp_q.delete();
      exp_tag_q.delete();
      due_q.delete();
    end else begin
      ev = (exp_q.size() > 0) && (cyc >= due_q[0]);
      chk("resp_valid", {63'b0, resp_valid}, {63'b0, ev});
      chk("busy", {63'b0, busy}, {63'b0, (exp_q.size() > 0)});
      chk("req_ready", {63'b0, req_ready},
          {63'b0, (!flush && ((exp_q.size() == 0) || (ev && resp_ready)))});
      if (ev) begin
        chk("resp_data", {32'b0, resp_data}, {32'b0, exp_q[0]});
        chk("resp_tag", {59'b0, resp_tag}, {59'b0, exp_tag_q[0]});
      end
      if (flush) begin
        exp_q.delete();
        exp_tag_q.delete();
        due_q.delete();
      end else begin
        if (ev && resp_ready) begin
          void'(exp_q.pop_front());
          void'(exp_tag_q.pop_front());
          void'(due_q.pop_front());
        end
        if (req_valid && req_ready) begin
          exp_q.push_back(ref_res(req_op, req_src1, req_src2));
          exp_tag_q.push_back(req_tag);
          due_q.push_back(cyc + (is_special(req_op, req_src1, req_src2) ? 1 : LAT));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                      output int acc_cyc);
    logic ok;
    ok        = 1'b0;
    acc_cyc   = -1;
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_tag   = tag;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
      if (ok) acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: req_ready never rose, op %0d", op);
    end
  endtask

  task automatic wait_resp(input string name, input logic [XLEN-1:0] ed,
                           input logic [TAG_W-1:0] et, output int v_cyc);
    logic got;
    got   = 1'b0;
    v_cyc = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        got   = 1'b1;
        v_cyc = cyc;
        chk(name, {32'b0, resp_data}, {32'b0, ed});
        chk({name, "_tag"}, {59'b0, resp_tag}, {59'b0, et});
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no response, expected %0h", name, ed);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] ed,
                        input int lat);
    int ac;
    int vc;
    send(op, a, b, tag, ac);
    wait_resp(name, ed, tag, vc);
    chk({name, "_lat"}, 64'(vc - ac), 64'(lat));
  endtask

  function automatic logic [XLEN-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int  ac;
    int  vc;
    logic acc;
    logic seen_valid;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_src1   = '0;
    req_src2   = '0;
    req_tag    = '0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_resp_data", {32'b0, resp_data}, 64'd0);
    chk("rst_resp_tag", {59'b0, resp_tag}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    rst = 1'b0;

    // multiply family
    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, LAT);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, LAT);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, LAT);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, LAT);
    // divide family
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, LAT);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, LAT);
    run_op("divu",   3'd5, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'h7FFF_FFFC, LAT);
    run_op("remu",   3'd7, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'h0000_0001, LAT);
    // special cases
    run_op("div_by0",  3'd4, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", 3'd7, 32'd5,         32'd0,         5'd12, 32'h0000_0005, 1);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1);

    // backpressure, then back-to-back accept on the releasing cycle
    resp_ready = 1'b0;
    send(3'd0, 32'd123, 32'd456, 5'd9, ac);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", {63'b0, resp_valid}, 64'd1);
      chk("bp_data", {32'b0, resp_data}, 64'd56088);
      chk("bp_tag", {59'b0, resp_tag}, 64'd9);
      chk("bp_req_ready", {63'b0, req_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    run_op("b2b_divu", 3'd5, 32'd1000, 32'd7, 5'd10, 32'd142, LAT);

    // flush in the middle of CALC
    send(3'd0, 32'h0000_FFFF, 32'h0000_FFFF, 5'd4, ac);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_req_ready", {63'b0, req_ready}, 64'd1);
    chk("flush_busy", {63'b0, busy}, 64'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) seen_valid = 1'b1;
    end
    chk("flush_no_resp", {63'b0, seen_valid}, 64'd0);
    @(posedge clk);
    #1;
    run_op("post_flush_mul", 3'd0, 32'd6, 32'd7, 5'd2, 32'd42, LAT);

    // reset in the middle of CALC
    send(3'd4, 32'd1000, 32'd3, 5'd7, ac);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("midrst_resp_data", {32'b0, resp_data}, 64'd0);
    chk("midrst_resp_tag", {59'b0, resp_tag}, 64'd0);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_req_ready", {63'b0, req_ready}, 64'd1);
    @(posedge clk);
    #1;

    // randomized traffic with backpressure and occasional flush
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (acc || !req_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          req_valid = 1'b1;
          req_op    = 3'($urandom_range(0, 7));
          req_src1  = rand_opnd();
          req_src2  = rand_opnd();
          req_tag   = 5'($urandom_range(0, 31));
        end else begin
          req_valid = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 149) == 0);
    end
    req_valid  = 1'b0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    repeat (LAT + 10) @(posedge clk);
    #1;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
